tx_prbs_modulator: RTL and testbench



---
 rtl/tx_pkg.sv | 55 +++++
 rtl/tx_sequence_rom.sv | 27 ++
 rtl/tx_prbs_modulator.sv | 148 ++++++++++++++
 tb/tb_tx_prbs_modulator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared constants for the BPSK PRBS transmit path.
// - SEQ_LEN / SAMPLES_PER_BIT : sequence length in bits, samples per bit
// - SINE_LUT                  : one carrier period, amplitude capped at 32767
// - SEQ_TABLE                 : the 16 transmit sequences (also used by the RX bit feeder)
// - tx_state_e                : modulator FSM states
package tx_pkg;

  localparam int SEQ_LEN         = 511;
  localparam int SAMPLES_PER_BIT = 20;
  localparam int NUM_SEQ         = 16;
  localparam int ADDR_W          = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } tx_state_e;

  // round(32767 * sin(2*pi*n/20)); peak is 32767 so the negated value always fits.
  localparam logic signed [15:0] SINE_LUT [SAMPLES_PER_BIT] = '{
    16'sd0,      16'sd10126,  16'sd19260,  16'sd26509,  16'sd31163,
    16'sd32767,  16'sd31163,  16'sd26509,  16'sd19260,  16'sd10126,
    16'sd0,     -16'sd10126, -16'sd19260, -16'sd26509, -16'sd31163,
   -16'sd32767, -16'sd31163, -16'sd26509, -16'sd19260, -16'sd10126
  };

  typedef logic [NUM_SEQ-1:0][SEQ_LEN-1:0] seq_table_t;

  // PRBS9 generator: recurrence a[n+9] = a[n] ^ a[n+4] (maximal length 511).
  // Bit b of the result is the b-th emitted bit; the LSB of the state is emitted first.
  function automatic logic [SEQ_LEN-1:0] prbs9_seq(input logic [8:0] seed);
    logic [8:0]         r;
    logic [SEQ_LEN-1:0] seq;
    r   = seed;
    seq = '0;
    for (int b = 0; b < SEQ_LEN; b++) begin
      seq[b] = r[0];
      r      = {r[0] ^ r[4], r[8:1]};
    end
    return seq;
  endfunction

  // Sequence i uses seed i+1, so the 16 sequences are distinct shifts of one m-sequence.
  function automatic seq_table_t build_seq_table();
    seq_table_t t;
    for (int i = 0; i < NUM_SEQ; i++) begin
      t[i] = prbs9_seq(9'(i + 1));
    end
    return t;
  endfunction

  localparam seq_table_t SEQ_TABLE = build_seq_table();

endpackage

// File: rtl/tx_sequence_rom.sv
// Sequence ROM: one registered read per cycle returning bit 'addr' of all 16 sequences.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   addr     : bit address within the sequence
//   word     : registered read data, word[i] = SEQ_TABLE[i][addr]
module tx_sequence_rom
  import tx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SEQ-1:0] word
);

  // NOTE: the table itself is a constant, so only the output register carries a reset.
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else begin
      for (int i = 0; i < NUM_SEQ; i++) begin
        word[i] <= SEQ_TABLE[i][addr];
      end
    end
  end

endmodule

// File: rtl/tx_prbs_modulator.sv
// BPSK PRBS modulator: on istart, sends sequence iseq_sel as SEQ_LEN bits, each bit one
// carrier period of SAMPLES_PER_BIT samples (bit 1 = carrier, bit 0 = inverted carrier).
// Ports:
//   ctx_clk, rtx_rst  : clock, asynchronous active-high reset
//   etx_en            : enable; low forces IDLE and zeroes the outputs
//   inew_sample_trig  : sample-rate strobe (>= 2 clocks apart)
//   istart, iseq_sel  : start pulse and sequence select (taken only in IDLE)
//   osample           : current signed sample, osample_valid pulses on each update
//   obusy             : high in LOAD/SEND/DONE, odone pulses at end of transmission
module tx_prbs_modulator
  import tx_pkg::*;
(
  input  logic               ctx_clk,
  input  logic               rtx_rst,
  input  logic               etx_en,
  input  logic               inew_sample_trig,
  input  logic               istart,
  input  logic [3:0]         iseq_sel,
  output logic signed [15:0] osample,
  output logic               osample_valid,
  output logic               obusy,
  output logic               odone
);

  tx_state_e          state, state_next;
  logic [3:0]         sel;
  logic [ADDR_W-1:0]  bit_idx;
  logic [4:0]         s_idx;
  logic               cur_bit;
  logic               next_bit;
  logic               prefetch_pending;
  logic [ADDR_W-1:0]  rom_addr;
  logic [NUM_SEQ-1:0] rom_word;
  logic               rom_bit;
  logic               emit;
  logic               last_sample_in_bit;
  logic               last_bit;

  tx_sequence_rom u_rom (
    .clk  (ctx_clk),
    .rst  (rtx_rst),
    .addr (rom_addr),
    .word (rom_word)
  );

  assign rom_bit            = rom_word[sel];
  assign emit               = (state == ST_SEND) && inew_sample_trig;
  assign last_sample_in_bit = (s_idx == 5'(SAMPLES_PER_BIT - 1));
  assign last_bit           = (bit_idx == ADDR_W'(SEQ_LEN - 1));
  assign obusy              = (state != ST_IDLE);

  // Address is bit 0 while idle (read for LOAD) and bit b+1 while sending (prefetch).
  // On the last bit the address is held so it never leaves the table.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rom_addr   = '0;
    state_next = state;
    if (state == ST_SEND) begin
      rom_addr = last_bit ? bit_idx : bit_idx + 1'b1;
    end
    case (state)
      ST_IDLE: if (istart) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: if (emit && last_sample_in_bit && last_bit) state_next = ST_DONE;
      ST_DONE: if (inew_sample_trig) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (!etx_en) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge ctx_clk or posedge rtx_rst) begin
    if (rtx_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge ctx_clk or posedge rtx_rst) begin
    if (rtx_rst) begin
      sel              <= '0;
      bit_idx          <= '0;
      s_idx            <= '0;
      cur_bit          <= 1'b0;
      next_bit         <= 1'b0;
      prefetch_pending <= 1'b0;
      osample          <= '0;
      osample_valid    <= 1'b0;
      odone            <= 1'b0;
    end else if (!etx_en) begin
      bit_idx          <= '0;
      s_idx            <= '0;
      cur_bit          <= 1'b0;
      next_bit         <= 1'b0;
      prefetch_pending <= 1'b0;
      osample          <= '0;
      osample_valid    <= 1'b0;
      odone            <= 1'b0;
    end else begin
      osample_valid    <= 1'b0;
      odone            <= 1'b0;
      prefetch_pending <= 1'b0;
      // A prefetch issued last cycle has its ROM data available now.
      if (prefetch_pending) begin
        next_bit <= rom_bit;
      end
      case (state)
        ST_IDLE: begin
          osample <= '0;
          if (istart) begin
            sel     <= iseq_sel;
            bit_idx <= '0;
            s_idx   <= '0;
          end
        end
        ST_LOAD: begin
          cur_bit <= rom_bit;
        end
        ST_SEND: begin
          if (inew_sample_trig) begin
            osample       <= cur_bit ? SINE_LUT[s_idx] : -SINE_LUT[s_idx];
            osample_valid <= 1'b1;
            if (s_idx == '0 && !last_bit) begin
              prefetch_pending <= 1'b1;
            end
            if (last_sample_in_bit) begin
              s_idx   <= '0;
              bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
              cur_bit <= next_bit;
            end else begin
              s_idx <= s_idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (inew_sample_trig) begin
            osample <= '0;
            odone   <= 1'b1;
          end
        end
        default: osample <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_prbs_modulator.sv
// Self-checking bench for tx_prbs_modulator: a transaction-level model predicts every
// output each cycle from the sine formula and an independently generated PRBS9 table.
module tb_tx_prbs_modulator;

  localparam int N_BITS = 511;
  localparam int SPB    = 20;
  localparam int TOTAL  = N_BITS * SPB;

  logic               ctx_clk = 1'b0;
  logic               rtx_rst = 1'b1;
  logic               etx_en  = 1'b0;
  logic               inew_sample_trig = 1'b0;
  logic               istart  = 1'b0;
  logic [3:0]         iseq_sel = 4'd0;
  logic signed [15:0] osample;
  logic               osample_valid;
  logic               obusy;
  logic               odone;

  tx_prbs_modulator dut (
    .ctx_clk          (ctx_clk),
    .rtx_rst          (rtx_rst),
    .etx_en           (etx_en),
    .inew_sample_trig (inew_sample_trig),
    .istart           (istart),
    .iseq_sel         (iseq_sel),
    .osample          (osample),
    .osample_valid    (osample_valid),
    .obusy            (obusy),
    .odone            (odone)
  );

  always #5 ctx_clk = ~ctx_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference tables
  bit seq_bits [16][N_BITS];
  int lut [SPB];

  function automatic int expected_sample(input int seq, input int idx);
    int b;
    int s;
    b = idx / SPB;
    s = idx % SPB;
    return seq_bits[seq][b] ? lut[s] : -lut[s];
  endfunction

  // Transaction-level model of the transmitter
  int m_idx = 0;
  int m_seq = 0;
  bit m_busy = 0;
  bit m_load = 0;
  int exp_sample = 0;
  bit exp_valid = 0;
  bit exp_done = 0;

  always @(posedge ctx_clk or posedge rtx_rst) begin
    if (rtx_rst) begin
      m_idx <= 0; m_busy <= 0; m_load <= 0;
      exp_sample <= 0; exp_valid <= 0; exp_done <= 0;
    end else begin
      exp_valid <= 0;
      exp_done  <= 0;
      if (!etx_en) begin
        m_busy <= 0; m_load <= 0; m_idx <= 0; exp_sample <= 0;
      end else if (!m_busy) begin
        exp_sample <= 0;
        if (istart) begin
          m_busy <= 1; m_load <= 1; m_seq <= int'(iseq_sel); m_idx <= 0;
        end
      end else if (m_load) begin
        m_load <= 0;
      end else if (inew_sample_trig) begin
        if (m_idx < TOTAL) begin
          exp_sample <= expected_sample(m_seq, m_idx);
          exp_valid  <= 1;
          m_idx      <= m_idx + 1;
        end else begin
          exp_sample <= 0;
          exp_done   <= 1;
          m_busy     <= 0;
        end
      end
    end
  end

  // Per-cycle comparison
  bit cmp_en = 0;
  int valid_cnt = 0;
  int done_cnt = 0;

  always @(negedge ctx_clk) begin
    if (cmp_en) begin
      check("osample", osample, exp_sample);
      check("osample_valid", osample_valid, exp_valid);
      check("odone", odone, exp_done);
      check("obusy", obusy, m_busy);
      if (osample_valid) valid_cnt <= valid_cnt + 1;
      if (odone) done_cnt <= done_cnt + 1;
    end
  end

  task automatic tick(input logic trig, input logic start, input logic [3:0] sel);
    inew_sample_trig = trig;
    istart           = start;
    iseq_sel         = sel;
    @(posedge ctx_clk);
    #1;
    inew_sample_trig = 1'b0;
    istart           = 1'b0;
  endtask

  // Drive trigs with random spacing until odone (stop_idx < 0) or until stop_idx samples.
  task automatic drive_tx(input int gap_lo, input int gap_hi, input int first_gap,
                          input int stop_idx, input int budget);
    int gap = first_gap;
    int cyc = 0;
    bit saw = 0;
    while (cyc < budget) begin
      if (gap == 0) begin
        tick(1'b1, 1'b0, 4'd0);
        gap = int'($urandom_range(gap_hi, gap_lo)) - 1;
      end else begin
        tick(1'b0, 1'b0, 4'd0);
        gap--;
      end
      cyc++;
      if (stop_idx < 0 && odone) begin saw = 1; break; end
      if (stop_idx >= 0 && m_idx >= stop_idx) break;
    end
    if (stop_idx < 0) check("done_seen", saw, 1);
    else check("reached_idx", m_idx, stop_idx);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int d0;
    int head;

    // Build reference PRBS9 table and sine LUT from their definitions.
    for (int k = 0; k < 16; k++) begin
      int r;
      r = k + 1;
      for (int b = 0; b < N_BITS; b++) begin
        int fb;
        seq_bits[k][b] = bit'(r & 1);
        fb = (r ^ (r >> 4)) & 1;
        r  = (r >> 1) | (fb << 8);
      end
    end
    for (int n = 0; n < SPB; n++) begin
      real v;
      v = 32767.0 * $sin(2.0 * 3.14159265358979 * n / SPB);
      lut[n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    end

    // Hand-computed pins of the model
    check("lut1", lut[1], 10126);
    check("lut2", lut[2], 19260);
    check("lut3", lut[3], 26509);
    check("lut4", lut[4], 31163);
    check("lut5", lut[5], 32767);
    check("lut10", lut[10], 0);
    check("lut15", lut[15], -32767);
    head = 0;
    for (int b = 0; b < 6; b++) head |= int'(seq_bits[0][b]) << b;
    check("seq0_head", head, 1);
    head = 0;
    for (int b = 0; b < 5; b++) head |= int'(seq_bits[15][b]) << b;
    check("seq15_head", head, 16);
    check("seq3_s5_sample", expected_sample(3, 5), seq_bits[3][0] ? 32767 : -32767);

    // Reset state
    repeat (3) @(posedge ctx_clk);
    #1;
    cmp_en = 1;
    check("rst_osample", osample, 0);
    check("rst_valid", osample_valid, 0);
    check("rst_busy", obusy, 0);
    check("rst_done", odone, 0);
    rtx_rst = 1'b0;
    etx_en  = 1'b1;
    tick(1'b0, 1'b0, 4'd0);

    // Full transmission, sequence 3, trig every 4 clocks
    v0 = valid_cnt;
    d0 = done_cnt;
    tick(1'b0, 1'b1, 4'd3);
    drive_tx(4, 4, 0, -1, 60000);
    check("A_osample_after_done", osample, 0);
    check("A_busy_at_done", obusy, 0);
    // Back-to-back: start in the first IDLE cycle after odone, sequence 15
    tick(1'b0, 1'b1, 4'd15);
    check("A_valid_count", valid_cnt - v0, TOTAL);
    check("A_done_count", done_cnt - d0, 1);
    check("B_busy_after_start", obusy, 1);

    // Minimum trig spacing, sequence 15
    v0 = valid_cnt;
    d0 = done_cnt;
    drive_tx(2, 2, 0, -1, 30000);
    tick(1'b0, 1'b0, 4'd0);
    check("B_valid_count", valid_cnt - v0, TOTAL);
    check("B_done_count", done_cnt - d0, 1);

    // Sequence 0: start coincident with a trig, ignored restart, then enable drop at b=100 s=7
    d0 = done_cnt;
    tick(1'b1, 1'b1, 4'd0);
    drive_tx(2, 4, 1, 500, 10000);
    tick(1'b0, 1'b1, 4'd7);
    check("C_busy_after_ignored_start", obusy, 1);
    drive_tx(2, 4, 0, 100 * SPB + 8, 20000);
    etx_en = 1'b0;
    tick(1'b0, 1'b0, 4'd0);
    check("C_drop_osample", osample, 0);
    check("C_drop_busy", obusy, 0);
    tick(1'b0, 1'b0, 4'd0);
    check("C_no_done", done_cnt - d0, 0);

    // Re-enable and restart from bit 0, then reset mid-SEND
    etx_en = 1'b1;
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'd5);
    drive_tx(2, 3, 0, 300, 5000);
    tick(1'b0, 1'b0, 4'd0);
    rtx_rst = 1'b1;
    #1;
    check("D_rst_osample", osample, 0);
    check("D_rst_busy", obusy, 0);
    check("D_rst_done", odone, 0);
    @(posedge ctx_clk);
    #1;
    rtx_rst = 1'b0;
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'd9);
    drive_tx(2, 5, 0, 100, 5000);
    tick(1'b0, 1'b0, 4'd0);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
